// File: rtl/control_display_7seg.sv
// Multiplexed seven-segment driver: sequential binary-to-BCD conversion (double dabble)
// feeding a display register, plus a free-running anode scanner with registered outputs.
module control_display_7seg #(
   parameter int unsigned N_BITS  = 4,
   parameter int unsigned N_DIG   = 2,
   parameter int unsigned REFRESH = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_BITS-1:0] bin,
   input  logic              load,
   input  logic              en,
   output logic              ready,
   output logic              done,
   output logic [6:0]        seg,
   output logic [N_DIG-1:0]  an
);

   localparam int unsigned BcdW = 4 * N_DIG;
   localparam int unsigned CntW = $clog2(N_BITS + 1);
   localparam int unsigned RefW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
   localparam int unsigned IdxW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

   typedef enum logic [1:0] {StIdle, StConv, StUpdate} state_e;

   state_e            state_q, state_d;
   logic [N_BITS-1:0] sr_q, sr_d;
   logic [BcdW-1:0]   bcd_q, bcd_d, bcd_adj;
   logic [BcdW-1:0]   disp_q, disp_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   logic [RefW-1:0]   ref_q;
   logic [IdxW-1:0]   idx_q;
   logic [3:0]        digit;
   logic [N_DIG-1:0]  an_sel;
   logic [6:0]        seg_d;
   logic [N_DIG-1:0]  an_d;

   // Active-low segment pattern {a..g}; non-decimal nibbles blank the digit.
   function automatic logic [6:0] dec(input logic [3:0] d);
      case (d)
         4'd0:    dec = 7'b000_0001;
         4'd1:    dec = 7'b100_1111;
         4'd2:    dec = 7'b001_0010;
         4'd3:    dec = 7'b000_0110;
         4'd4:    dec = 7'b100_1100;
         4'd5:    dec = 7'b010_0100;
         4'd6:    dec = 7'b010_0000;
         4'd7:    dec = 7'b000_1111;
         4'd8:    dec = 7'b000_0000;
         4'd9:    dec = 7'b000_0100;
         default: dec = 7'h7F;
      endcase
   endfunction

   // Add 3 to every BCD nibble >= 5; nibbles are independent, no carry between them.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < N_DIG; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   // Conversion FSM next-state and handshake outputs.
   always_comb begin
      state_d = state_q;
      sr_d    = sr_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      disp_d  = disp_q;
      ready   = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            ready = 1'b1;
            if (load) begin
               sr_d    = bin;
               bcd_d   = '0;
               cnt_d   = '0;
               state_d = StConv;
            end
         end
         StConv: begin
            {bcd_d, sr_d} = {bcd_adj, sr_q} << 1;
            cnt_d         = cnt_q + CntW'(1);
            if (cnt_q == CntW'(N_BITS - 1)) begin
               state_d = StUpdate;
            end
         end
         StUpdate: begin
            disp_d  = bcd_q;
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Conversion state and display register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         sr_q    <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         disp_q  <= '0;
      end else begin
         state_q <= state_d;
         sr_q    <= sr_d;
         bcd_q   <= bcd_d;
         cnt_q   <= cnt_d;
         disp_q  <= disp_d;
      end
   end

   // Refresh counter and digit index; runs regardless of en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ref_q <= '0;
         idx_q <= '0;
      end else if (ref_q == RefW'(REFRESH - 1)) begin
         ref_q <= '0;
         idx_q <= (idx_q == IdxW'(N_DIG - 1)) ? '0 : idx_q + IdxW'(1);
      end else begin
         ref_q <= ref_q + RefW'(1);
      end
   end

   // Select the digit and anode for the current index, blanking when disabled.
   always_comb begin
      digit  = '0;
      an_sel = '1;
      for (int i = 0; i < N_DIG; i++) begin
         if (idx_q == IdxW'(i)) begin
            digit     = disp_q[4*i +: 4];
            an_sel[i] = 1'b0;
         end
      end
      seg_d = en ? dec(digit) : 7'h7F;
      an_d  = en ? an_sel : '1;
   end

   // Registered pins; they lag an index or enable change by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= 7'h7F;
         an  <= '1;
      end else begin
         seg <= seg_d;
         an  <= an_d;
      end
   end

endmodule

// File: tb/tb_control_display_7seg.sv
// Scoreboard bench for control_display_7seg with REFRESH=4: stimulus pushes expected
// digits, a monitor pops them on every done pulse and checks latency and the committed digit.
module tb_control_display_7seg;

   localparam int unsigned N_BITS  = 4;
   localparam int unsigned N_DIG   = 2;
   localparam int unsigned REFRESH = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N_BITS-1:0] bin;
   logic              load;
   logic              en;
   logic              ready;
   logic              done;
   logic [6:0]        seg;
   logic [N_DIG-1:0]  an;

   typedef struct {
      int tens;
      int units;
      int acc;
   } exp_t;

   exp_t q[$];
   int   n_cmp  = 0;
   int   n_err  = 0;
   int   n_done = 0;
   int   cyc    = 0;
   int   done_before;
   int   n;

   logic [6:0] dec_tab [0:9] = '{7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
                                 7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
                                 7'b000_0000, 7'b000_0100};

   control_display_7seg #(
      .N_BITS (N_BITS),
      .N_DIG  (N_DIG),
      .REFRESH(REFRESH)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bin  (bin),
      .load (load),
      .en   (en),
      .ready(ready),
      .done (done),
      .seg  (seg),
      .an   (an)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_ready();
      int k = 0;
      while (ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (k == 20) check("ready_timeout", 32'(ready), 1);
   endtask

   // Sample the scan for a number of cycles and match each lit digit.
   task automatic check_display(input int tens, input int units, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (an === 2'b10) check("disp_units", seg, dec_tab[units]);
         else if (an === 2'b01) check("disp_tens", seg, dec_tab[tens]);
         else check("disp_an_onehot", an, 2'b10);
      end
   endtask

   task automatic issue(input int v);
      exp_t e;
      bin     = N_BITS'(v);
      load    = 1'b1;
      e.tens  = v / 10;
      e.units = v % 10;
      e.acc   = cyc + 1;
      q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: pop an expectation on each done pulse and check it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && done === 1'b1) begin
            n_done++;
            check("done_has_expected", 32'(q.size() != 0), 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               check("done_latency", cyc - e.acc, N_BITS);
               @(negedge clk);
               check("done_width", 32'(done), 0);
               @(negedge clk);
               if (an === 2'b10) check("commit_units", seg, dec_tab[e.units]);
               else check("commit_tens", seg, dec_tab[e.tens]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      load  = 1'b0;
      en    = 1'b0;
      bin   = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 32'(ready), 1);
      check("rst_done", 32'(done), 0);
      check("rst_seg", seg, 7'h7F);
      check("rst_an", an, 2'b11);

      // Scan sequence after reset with zeros displayed.
      rst_n = 1'b1;
      en    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("scan_an", an, (i < 4) ? 2'b10 : 2'b01);
         check("scan_seg", seg, 7'b000_0001);
      end

      // Single conversion of 13.
      wait_ready();
      issue(13);
      load = 1'b0;
      n = 0;
      while (ready === 1'b0 && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("ready_low_cycles", n, N_BITS + 1);
      repeat (3) @(negedge clk);
      check_display(1, 3, 8);

      // Blanking and resume.
      en = 1'b0;
      @(negedge clk);
      check("blank_seg", seg, 7'h7F);
      check("blank_an", an, 2'b11);
      en = 1'b1;
      check_display(1, 3, 1);

      // Load while busy is ignored.
      wait_ready();
      done_before = n_done;
      issue(15);
      bin = 4'd9;
      @(negedge clk);
      load = 1'b0;
      wait_ready();
      repeat (3) @(negedge clk);
      check("busy_load_ignored", n_done - done_before, 1);
      check_display(1, 5, 8);

      // Reset in the middle of a conversion.
      wait_ready();
      issue(9);
      load = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_an", an, 2'b11);
      check("midrst_seg", seg, 7'h7F);
      check("midrst_ready", 32'(ready), 1);
      q.delete();
      done_before = n_done;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check_display(0, 0, 8);
      check("midrst_ready_after", 32'(ready), 1);
      check("midrst_no_done", n_done - done_before, 0);

      // Back-to-back sweep with load held high.
      done_before = n_done;
      for (int v = 0; v < 16; v++) begin
         wait_ready();
         issue(v);
      end
      load = 1'b0;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("sweep_drain", q.size(), 0);
      repeat (3) @(negedge clk);
      check("sweep_done_count", n_done - done_before, 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
